bram_arbiter: RTL

//  Shares one 1024x8 bram (registered read, 1-cycle read latency, separate rd/wr ports)

---
 rtl/bram_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one registered-read bram between two clients,
// with a fill engine that sweeps a constant over every word.
module bram_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_value,
  output logic              fill_busy,
  input  logic              c0_req,
  input  logic              c0_we,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_wdata,
  output logic              c0_gnt,
  output logic              c0_rvalid,
  output logic [DATA_W-1:0] c0_rdata,
  input  logic              c1_req,
  input  logic              c1_we,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic              c1_gnt,
  output logic              c1_rvalid,
  output logic [DATA_W-1:0] c1_rdata,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data
);

  // state | meaning
  // ARB   | clients arbitrated round-robin, one bram op per cycle
  // FILL  | fill sweep owns the write port, clients stalled
  typedef enum logic {ARB, FILL} state_t;

  state_t            state, state_nxt;
  logic              last_c1;
  logic [ADDR_W-1:0] fill_cnt;
  logic [DATA_W-1:0] fill_data;
  logic              fill_last;
  logic              fill_go;
  logic              gnt0, gnt1;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [1:0]        tag1, tag2;

  // fill_cnt always equals the address being written during FILL
  assign fill_last = (fill_cnt == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= ARB;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    fill_go   = 1'b0;
    if (!rst) begin
      case (state)
        ARB: begin
          if (fill_start) begin
            fill_go   = 1'b1;
            state_nxt = FILL;
          end else begin
            gnt0 = c0_req && (!c1_req || last_c1);
            gnt1 = c1_req && (!c0_req || !last_c1);
          end
        end
        FILL: if (fill_last) state_nxt = ARB;
        default: state_nxt = ARB;
      endcase
    end
  end

  assign c0_gnt    = gnt0;
  assign c1_gnt    = gnt1;
  assign sel_we    = gnt1 ? c1_we    : c0_we;
  assign sel_addr  = gnt1 ? c1_addr  : c0_addr;
  assign sel_wdata = gnt1 ? c1_wdata : c0_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_busy   <= 1'b0;
      last_c1     <= 1'b1;
      fill_cnt    <= '0;
      fill_data   <= '0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      tag1        <= '0;
      tag2        <= '0;
    end else begin
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      fill_busy <= (state_nxt == FILL);
      // tag = {valid read, client}; stage 2 lines up with mem_rd_data
      tag1      <= {(gnt0 | gnt1) & ~sel_we, gnt1};
      tag2      <= tag1;
      if (fill_go) begin
        fill_data   <= fill_value;
        fill_cnt    <= '0;
        mem_wr_en   <= 1'b1;
        mem_wr_addr <= '0;
        mem_wr_data <= fill_value;
      end else if (state == FILL && !fill_last) begin
        fill_cnt    <= fill_cnt + 1'b1;
        mem_wr_en   <= 1'b1;
        mem_wr_addr <= fill_cnt + 1'b1;
        mem_wr_data <= fill_data;
      end else if (gnt0 | gnt1) begin
        last_c1 <= gnt1;
        if (sel_we) begin
          mem_wr_en   <= 1'b1;
          mem_wr_addr <= sel_addr;
          mem_wr_data <= sel_wdata;
        end else begin
          mem_rd_en   <= 1'b1;
          mem_rd_addr <= sel_addr;
        end
      end
    end
  end

  assign c0_rvalid = tag2[1] & ~tag2[0];
  assign c1_rvalid = tag2[1] &  tag2[0];
  assign c0_rdata  = mem_rd_data;
  assign c1_rdata  = mem_rd_data;

endmodule
